// File: rtl/fifo_rr_scheduler.sv
// fifo_rr_scheduler: round-robin write arbiter plus fixed-rate read pacer that
// shares one fifo between NUM_REQ writers. Occupancy is tracked with a credit
// counter so the fifo itself needs no status pins.
//
// Handshake: a requester raises reqIn[i] with its word on dataIn and holds both
// stable until it sees grantOut[i] high for one cycle; the word is then written.
// A request still high after the grant is treated as a new request, but the
// requester just granted is skipped for one cycle so others get a turn.
module fifo_rr_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 6,
  parameter int ENTRIES     = 2,
  parameter int READ_PERIOD = 8
) (
  input  logic                          clkIn,
  input  logic                          resetIn,
  input  logic [NUM_REQ-1:0]            reqIn,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] dataIn,
  output logic [NUM_REQ-1:0]            grantOut,
  output logic                          fifoWriteEnableOut,
  output logic [DATA_WIDTH-1:0]         fifoDataOut,
  output logic                          fifoReadEnableOut,
  output logic [$clog2(ENTRIES+1)-1:0]  levelOut
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int LVL_W = $clog2(ENTRIES + 1);
  localparam int CNT_W = (READ_PERIOD > 1) ? $clog2(READ_PERIOD) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(READ_PERIOD - 1);
  localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(ENTRIES);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  rd_q, rd_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [NUM_REQ-1:0]    eligible;
  logic                  win_found;
  logic [PTR_W-1:0]      win_idx;
  int                    cand;
  logic                  grant_fire;
  logic                  read_fire;

  // Pick the first eligible requester scanning from the rotate pointer; no grant at full.
  always_comb begin
    eligible  = reqIn & ~grant_q;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = (int'(ptr_q) + off) % NUM_REQ;
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(cand);
      end
    end
    grant_fire = win_found && (level_q < LVL_MAX);
    read_fire  = (cnt_q == CNT_MAX) && (level_q != '0);
  end

  // Next-state for grant/write outputs, pointer, read pacer and credit level.
  always_comb begin
    grant_d = '0;
    we_d    = 1'b0;
    data_d  = data_q;
    ptr_d   = ptr_q;
    rd_d    = read_fire;
    cnt_d   = cnt_q;
    level_d = level_q;

    if (grant_fire) begin
      grant_d[win_idx] = 1'b1;
      we_d             = 1'b1;
      data_d           = dataIn[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
      ptr_d            = (win_idx == PTR_LAST) ? '0 : win_idx + PTR_W'(1);
    end

    // Counter saturates at the period and waits there until there is data to read.
    if (read_fire) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Simultaneous write and read cancel out.
    case ({grant_fire, read_fire})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // State registers; asynchronous reset clears everything including in-flight pulses.
  always_ff @(posedge clkIn or posedge resetIn) begin
    if (resetIn) begin
      grant_q <= '0;
      we_q    <= 1'b0;
      data_q  <= '0;
      rd_q    <= 1'b0;
      level_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      grant_q <= grant_d;
      we_q    <= we_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grantOut           = grant_q;
  assign fifoWriteEnableOut = we_q;
  assign fifoDataOut        = data_q;
  assign fifoReadEnableOut  = rd_q;
  assign levelOut           = level_q;

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Bench for fifo_rr_scheduler: random requesters, a queue-based reference model
// that pushes expected outputs per cycle, and a monitor that pops and compares.
module tb_fifo_rr_scheduler;

  localparam int NUM_REQ = 4;
  localparam int DW      = 6;
  localparam int ENT     = 2;
  localparam int RP      = 8;
  localparam int LW      = $clog2(ENT + 1);
  localparam int EW      = NUM_REQ + 1 + DW + 1 + LW;

  logic                     clk;
  logic                     rst;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*DW-1:0]    din;
  logic [NUM_REQ-1:0]       grant;
  logic                     we;
  logic [DW-1:0]            dout;
  logic                     rd;
  logic [LW-1:0]            level;

  logic [EW-1:0] exp_q[$];
  int  tests;
  int  fails;
  bit  in_reset;

  // reference model state
  int            m_level;
  int            m_ptr;
  int            m_timer;
  int            m_last;
  logic [DW-1:0] m_data;

  // requester state for the hold-until-granted protocol
  logic [NUM_REQ-1:0] pend;
  logic [DW-1:0]      pend_data[NUM_REQ];

  fifo_rr_scheduler #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .ENTRIES(ENT), .READ_PERIOD(RP)
  ) dut (
    .clkIn(clk), .resetIn(rst), .reqIn(req), .dataIn(din),
    .grantOut(grant), .fifoWriteEnableOut(we), .fifoDataOut(dout),
    .fifoReadEnableOut(rd), .levelOut(level)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_level = 0;
    m_ptr   = 0;
    m_timer = 0;
    m_last  = -1;
    m_data  = '0;
    pend    = '0;
  endtask

  // One clock edge of the behaviour, from the rules: rotate search, one-cycle
  // mask on the last winner, credit gate, saturating read timer.
  task automatic model_step();
    int                 winner;
    logic [NUM_REQ-1:0] g;
    logic               w;
    logic               r;
    winner = -1;
    if (m_level < ENT) begin
      for (int off = 0; off < NUM_REQ; off++) begin
        int i;
        i = (m_ptr + off) % NUM_REQ;
        if (winner < 0 && req[i] && i != m_last) winner = i;
      end
    end
    r = (m_timer == RP - 1) && (m_level > 0);
    g = '0;
    w = 1'b0;
    if (winner >= 0) begin
      g[winner] = 1'b1;
      w         = 1'b1;
      m_data    = din[winner*DW +: DW];
      m_ptr     = (winner + 1) % NUM_REQ;
      m_level   = m_level + 1;
    end
    m_last = winner;
    if (r) m_level = m_level - 1;
    if (r) m_timer = 0;
    else if (m_timer < RP - 1) m_timer = m_timer + 1;
    exp_q.push_back({g, w, m_data, r, LW'(m_level)});
  endtask

  // driver: apply inputs (called at a falling edge), step model at the rising edge
  task automatic drive_cycle(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ*DW-1:0] d);
    req = r;
    din = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic random_cycle();
    drive_cycle(NUM_REQ'($urandom), (NUM_REQ*DW)'({$urandom, $urandom}));
  endtask

  // requesters hold until granted, then usually drop; sometimes keep asking
  task automatic hold_cycle();
    logic [NUM_REQ-1:0]    r;
    logic [NUM_REQ*DW-1:0] d;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pend[i] && m_last == i && $urandom_range(0, 3) != 0) pend[i] = 1'b0;
      if (!pend[i] && $urandom_range(0, 2) == 0) begin
        pend[i]      = 1'b1;
        pend_data[i] = DW'($urandom);
      end
    end
    r = pend;
    d = '0;
    for (int i = 0; i < NUM_REQ; i++) d[i*DW +: DW] = pend_data[i];
    drive_cycle(r, d);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_grant"}, int'(grant), 0);
    check({tag, "_we"},    int'(we),    0);
    check({tag, "_data"},  int'(dout),  0);
    check({tag, "_rd"},    int'(rd),    0);
    check({tag, "_level"}, int'(level), 0);
  endtask

  // asynchronous assert in the middle of a low phase; outputs must clear at once
  task automatic do_reset(input string tag);
    #2;
    rst      = 1'b1;
    in_reset = 1'b1;
    #1;
    check_zero(tag);
    exp_q.delete();
    model_reset();
    req = '0;
    @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    in_reset = 1'b0;
  endtask

  // scoreboard monitor: pop one expected vector per cycle and compare field by field
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!in_reset && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("grant", int'(grant), int'(e[EW-1 -: NUM_REQ]));
      check("we",    int'(we),    int'(e[DW+1+LW]));
      check("data",  int'(dout),  int'(e[LW+1 +: DW]));
      check("rd",    int'(rd),    int'(e[LW]));
      check("level", int'(level), int'(e[LW-1:0]));
    end
  end

  initial begin
    logic [NUM_REQ*DW-1:0] d;
    tests    = 0;
    fails    = 0;
    in_reset = 1'b1;
    rst      = 1'b1;
    req      = '0;
    din      = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst      = 1'b0;
    in_reset = 1'b0;

    // single request from index 2 with word 0x15
    d = '0;
    d[2*DW +: DW] = 6'h15;
    drive_cycle(4'b0100, d);
    repeat (3) drive_cycle('0, '0);

    // one requester held: alternate-cycle grants until full, then read-paced
    d = '0;
    d[0 +: DW] = 6'h2a;
    repeat (30) drive_cycle(4'b0001, d);
    repeat (20) drive_cycle('0, '0);

    repeat (400) hold_cycle();
    do_reset("midreset");
    // lowest requesting index wins first after reset
    d = {6'h11, 6'h22, 6'h33, 6'h0f};
    drive_cycle(4'b1010, d);
    repeat (400) random_cycle();
    repeat (40) drive_cycle('0, '0);
    do_reset("midreset2");
    repeat (300) hold_cycle();
    drive_cycle('0, '0);

    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
